shift_load_ctrl: RTL and testbench
==================================

# shift_load_ctrl

Sequencer that loads a parallel word into a serial-in/parallel-out shift chain one bit per clock, then presents the settled parallel contents downstream. Upstream uses a valid/ready handshake to hand over words. Downstream uses a valid/ready handshake to take the result. The block owns the shift chain, counts the shifts and guarantees downstream never sees a partially shifted word. It sits between a word producer and any consumer of the shift register's parallel taps.

## Interface
Parameters:
- WIDTH, 4, number of shift stages and data bits (legal range 2..32)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word available
- in_ready  out  1  block can accept a word this cycle
- in_data  in  WIDTH  word to load
- shift_en  out  1  shift chain advances at the end of this cycle
- ser_out  out  1  bit driven into stage 1 of the chain this cycle
- out_valid  out  1  out_data holds a complete word
- out_ready  in  1  downstream takes the word
- out_data  out  WIDTH  parallel taps; out_data[WIDTH-1] is the last stage
- busy  out  1  high in SHIFT or HOLD

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture in_data into hold_word, set cnt=0 and go to SHIFT.
  - SHIFT: shift_en=1 and ser_out=hold_word[WIDTH-1-cnt] (MSB first). cnt increments every cycle. When cnt==WIDTH-1 in a cycle, go to HOLD.
  - HOLD: out_valid=1 and the chain is frozen (shift_en=0).
    - out_ready=1 and in_valid=1: capture the new word, cnt=0, go to SHIFT (back-to-back). in_ready=out_ready in HOLD.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=0: stay in HOLD. out_data must not change.
- After WIDTH shifts, the chain holds the loaded word in order: out_data == captured in_data, with MSB at the last stage.
- in_ready=0 in SHIFT. in_valid there is ignored and does not count as a handshake.
- The chain contents persist in IDLE. out_valid=0 in IDLE.
- cnt width is $clog2(WIDTH). cnt never wraps past WIDTH-1.

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, hold_word=0, chain=0.
  - After reset: in_ready=1, shift_en=0, ser_out=0, out_valid=0, out_data=0, busy=0.
- Reset takes priority over every handshake. A reset mid-SHIFT or mid-HOLD discards the word, and no out_valid follows.
- Latency: a word accepted at edge E drives shift_en at edges E+1..E+WIDTH. out_valid rises in the cycle after edge E+WIDTH, i.e. WIDTH+1 cycles after acceptance.
- Throughput with out_ready held high and back-to-back in_valid: one word per WIDTH+1 cycles.
- out_valid, once high, stays high with stable out_data until the out_ready handshake completes.
- All outputs are registered state or decoded from state/cnt/hold_word only. There are no combinational paths from in_valid or out_ready to shift_en or out_valid. in_ready in HOLD is the single exception and equals out_ready.

## Structure
- Package shift_load_pkg:
  - state_t enum {IDLE, SHIFT, HOLD}
  - DEFAULT_WIDTH = 4
  - function cnt_bits(WIDTH) returning $clog2(WIDTH)
- Sub-module shift_chain:
  - WIDTH stages with synchronous reset and a shift enable.
  - Serial input feeds stage 1. Stage k feeds stage k+1.
  - Parallel outputs Q[1..WIDTH] map to out_data[0..WIDTH-1].
  - Instantiated once. The FSM, counter and hold register live in shift_load_ctrl.

## Test plan
- Reset with WIDTH=4: hold rst for 2 cycles, then release. Check in_ready=1, out_valid=0, out_data=4'b0000 and busy=0 immediately after reset.
- Single word, out_ready=1: send in_data=4'b1011. Check ser_out sequence 1,0,1,1 on 4 consecutive shift_en cycles. Check out_valid=1 with out_data=4'b1011 exactly 5 cycles after acceptance, then a return to IDLE.
- Backpressure: send 4'b0110 with out_ready=0 for 6 cycles. Check out_valid stays high, out_data=4'b0110 is stable, and shift_en=0 throughout HOLD. Then pulse out_ready and check the return to IDLE.
- Back-to-back: send 4'b1111 then 4'b0001 with in_valid and out_ready continuously high. Check out_data=4'b1111 and then 4'b0001, with out_valid pulses 5 cycles apart and in_valid ignored during SHIFT.
- Reset mid-shift: assert rst after 2 of 4 shifts of 4'b1001. Check chain=0, state=IDLE and no out_valid. Then send 4'b0101 and check a correct result.
- WIDTH=8 instance: send 8'hA5. Check 8 shift_en cycles, MSB-first ser_out, and out_data=8'hA5 9 cycles after acceptance.

Source files
------------

// File: rtl/shift_load_pkg.sv
// Shared types and helpers for the shift_load_ctrl slice.
// Contents: FSM state encoding, default chain width, counter width helper.
// Imported by shift_chain and shift_load_ctrl.
package shift_load_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to count shifts 0..width-1.
  function automatic int cnt_bits(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_chain.sv
// Serial-in / parallel-out shift chain with synchronous reset.
// Latency: one stage per enabled clock; q updates on the rising edge.
// Ports: clk, rst, shift_en, ser_in (feeds stage 1), q[k-1] = stage k.
module shift_chain
  import shift_load_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  // Stage 1 sits at bit 0, so the first bit shifted in ends up at q[WIDTH-1].
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], ser_in};
    end
  end

endmodule

// File: rtl/shift_load_ctrl.sv
// Loads a parallel word MSB-first into a shift chain, then presents the taps.
// Latency: WIDTH+1 cycles from input handshake to out_valid.
// Backpressure: HOLD freezes the chain until out_ready; in_ready is low while shifting.
// Ports: clk, rst (sync, active high), in_valid/in_ready/in_data upstream,
//        out_valid/out_ready/out_data downstream, shift_en/ser_out chain drive, busy.
module shift_load_ctrl
  import shift_load_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             shift_en,
  output logic             ser_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] hold_word;
  logic [CW-1:0]   bit_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_word <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold_word <= in_data;
            cnt       <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // Counter saturates at LAST; leaving SHIFT resets it on the next load.
          if (cnt == LAST) begin
            state <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (in_valid) begin
              hold_word <= in_data;
              cnt       <= '0;
              state     <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MSB first: shift k drives hold_word[WIDTH-1-k].
  assign bit_idx   = LAST - cnt;
  assign shift_en  = (state == SHIFT);
  assign ser_out   = (state == SHIFT) ? hold_word[bit_idx] : 1'b0;
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  // Only path from a handshake input to an output: accepting in HOLD needs the
  // current word to leave in the same cycle.
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);

  shift_chain #(.WIDTH(WIDTH)) u_chain (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .ser_in   (ser_out),
    .q        (out_data)
  );

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench for shift_load_ctrl: WIDTH=4 and WIDTH=8 instances against a
// transaction-timed reference model (acceptance cycle + word + chain value).
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_shift_load_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus (index 0: WIDTH=4, index 1: WIDTH=8).
  logic        s_rst [2];
  logic        s_iv  [2];
  logic [31:0] s_dat [2];
  logic        s_ordy[2];

  logic        o_ir [2];
  logic        o_sh [2];
  logic        o_ser[2];
  logic        o_ov [2];
  logic        o_bsy[2];
  logic [3:0]  od4;
  logic [7:0]  od8;
  logic [3:0]  id4;
  logic [7:0]  id8;

  assign id4 = s_dat[0][3:0];
  assign id8 = s_dat[1][7:0];

  shift_load_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(s_rst[0]), .in_valid(s_iv[0]), .in_ready(o_ir[0]),
    .in_data(id4), .shift_en(o_sh[0]), .ser_out(o_ser[0]), .out_valid(o_ov[0]),
    .out_ready(s_ordy[0]), .out_data(od4), .busy(o_bsy[0])
  );

  shift_load_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(s_rst[1]), .in_valid(s_iv[1]), .in_ready(o_ir[1]),
    .in_data(id8), .shift_en(o_sh[1]), .ser_out(o_ser[1]), .out_valid(o_ov[1]),
    .out_ready(s_ordy[1]), .out_data(od8), .busy(o_bsy[1])
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: a word accepted in cycle acc shifts in cycles
  // acc+1..acc+W and is presented from cycle acc+W+1 until taken.
  int          mw[2] = '{4, 8};
  bit          mhave[2];
  int          macc[2];
  logic [31:0] mword[2];
  logic [31:0] mchain[2];
  bit          armed[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic drive(input int d, input logic r, input logic iv,
                       input logic [31:0] dat, input logic ordy);
    s_rst[d]  = r;
    s_iv[d]   = iv;
    s_dat[d]  = dat;
    s_ordy[d] = ordy;
  endtask

  // Check this cycle's outputs, advance the model, move to the next cycle.
  task automatic tick();
    int          w, j;
    bit          sh, hd;
    logic        eser, eir;
    logic [31:0] mask, got_od;
    string       p;
    #1;
    for (int d = 0; d < 2; d++) begin
      w    = mw[d];
      mask = (32'h1 << w) - 32'h1;
      sh   = mhave[d] && (cyc > macc[d]) && (cyc <= macc[d] + w);
      hd   = mhave[d] && (cyc > macc[d] + w);
      j    = cyc - macc[d] - 1;
      eser = sh ? mword[d][w-1-j] : 1'b0;
      eir  = !mhave[d] || (hd && s_ordy[d]);
      got_od = (d == 0) ? {28'd0, od4} : {24'd0, od8};
      p = (d == 0) ? "w4" : "w8";
      if (armed[d]) begin
        check({p, " in_ready"},  {31'd0, o_ir[d]},  {31'd0, eir});
        check({p, " shift_en"},  {31'd0, o_sh[d]},  {31'd0, sh});
        check({p, " ser_out"},   {31'd0, o_ser[d]}, {31'd0, eser});
        check({p, " out_valid"}, {31'd0, o_ov[d]},  {31'd0, hd});
        check({p, " busy"},      {31'd0, o_bsy[d]}, {31'd0, mhave[d]});
        check({p, " out_data"},  got_od,            mchain[d]);
        if (hd) check({p, " result"}, got_od, mword[d]);
      end
      if (s_rst[d]) begin
        mhave[d]  = 1'b0;
        mchain[d] = 32'd0;
        armed[d]  = 1'b1;
      end else begin
        if (sh) mchain[d] = ((mchain[d] << 1) | {31'd0, eser}) & mask;
        if (hd && s_ordy[d]) mhave[d] = 1'b0;
        if (s_iv[d] && eir) begin
          mhave[d] = 1'b1;
          macc[d]  = cyc;
          mword[d] = s_dat[d] & mask;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int d, input int n, input logic ordy);
    for (int i = 0; i < n; i++) begin
      drive(d, 1'b0, 1'b0, 32'd0, ordy);
      tick();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b1, 1'b0, 32'd0, 1'b1);
      mhave[d] = 1'b0; macc[d] = 0; mword[d] = 0; mchain[d] = 0; armed[d] = 1'b0;
    end
    tick(); tick();
    drive(0, 1'b0, 1'b0, 32'd0, 1'b1);
    drive(1, 1'b0, 1'b0, 32'd0, 1'b1);

    // Single word, consumer always ready.
    drive(0, 1'b0, 1'b1, 32'hB, 1'b1); tick();
    idle_cycles(0, 8, 1'b1);

    // Backpressure: result held for several cycles, then taken.
    drive(0, 1'b0, 1'b1, 32'h6, 1'b0); tick();
    idle_cycles(0, 10, 1'b0);
    idle_cycles(0, 3, 1'b1);

    // Back-to-back: second word offered throughout the first word's shift.
    drive(0, 1'b0, 1'b1, 32'hF, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0, 1'b1, 32'h1, 1'b1); tick();
    end
    idle_cycles(0, 7, 1'b1);

    // Reset after two shifts, then a clean word.
    drive(0, 1'b0, 1'b1, 32'h9, 1'b1); tick();
    idle_cycles(0, 2, 1'b1);
    drive(0, 1'b1, 1'b1, 32'h3, 1'b1); tick();
    idle_cycles(0, 3, 1'b1);
    drive(0, 1'b0, 1'b1, 32'h5, 1'b1); tick();
    idle_cycles(0, 7, 1'b1);

    // Wide instance.
    drive(1, 1'b0, 1'b1, 32'hA5, 1'b1); tick();
    idle_cycles(1, 11, 1'b1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, ($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1),
              $urandom, ($urandom_range(0, 9) < 6));
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
